lfgm_seq_ctrl: RTL
==================

Name: lfgm_seq_ctrl

Overview:
Parametrised generation sequencer for the life-game engine, successor to the fixed 60-row controller.
- Sequences the read / neighbour-check / judge / write pass over a ROWS-line cell RAM bounded by two wall lines.
- Generalises row count, address width and generation-counter width, and makes the trigger divider runtime-programmable.
- Adds pause/single-step, a busy flag, a done pulse and trigger-overrun detection.
- Drives the RAM ping-pong face select and the cell-engine phase bus.

Parameters:
ROWS, 60, cell rows; RAM lines 0 and ROWS+1 are walls
ADR_W, 6, RAM address width; must satisfy ROWS+2 <= 2**ADR_W
GEN_W, 24, generation counter width
DIV_W, 7, width of trg_div

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_trg  in  1  asynchronous tick; a falling edge counts one tick
trg_div  in  DIV_W  ticks per generation; 0 is treated as 1
run_en  in  1  1 = free-run on divided ticks, 0 = paused
step_req  in  1  one-cycle pulse; starts one generation while paused
rgen_trg  in  1  request regeneration (random reseed) at the next generation
state  out  5  lfgm_pkg::state_t, current phase, consumed by the cell engine
gnrt_cnt  out  GEN_W  generations started, wraps modulo 2**GEN_W
rgen_en  out  1  regeneration enable for the current generation
adr  out  ADR_W  RAM address: wr_adr in S_WRITE, otherwise rd_adr
rd_en  out  1  high in S_PRE_READ and S_READ
wr_en  out  1  high in S_WRITE
wcf  out  1  1 = cell line (wr_adr in 1..ROWS), 0 = wall line; combinational from wr_adr
ram_face  out  1  RAM face select; toggles at each generation start
busy  out  1  high whenever state != S_IDLE
gen_done  out  1  one-cycle pulse on the cycle the FSM leaves the final S_WRITE
overrun  out  1  sticky; set when a divided tick arrives while busy

Behaviour:
Reset values:
- state = S_IDLE; rd_adr = wr_adr = ROWS+1 (parked).
- gnrt_cnt, rgen_en, ram_face, gen_done, overrun, the rgen latch and the divider count all 0.
- Reset mid-generation aborts immediately: no further wr_en is issued.

Trigger path:
- start_trg passes through a 2-flop synchroniser (s1, s0).
- fall = s1 & ~s0.
- On each fall, the divider counts 0..max(trg_div,1)-1; wrapping from the top value produces a registered one-cycle tick.
- A trg_div change takes effect from the next wrap; a count already above the new top wraps at the next fall.

Generation start (start_go):
- start_go = (tick & run_en | step_req & ~run_en) & ~busy.
- step_req while run_en = 1, or while busy, is ignored.
- A tick while busy is dropped and sets overrun.
- On start_go, registered: rd_adr = wr_adr = 0, ram_face toggles, gnrt_cnt +1, rgen_en = rgen latch, latch cleared, state = S_PRE_READ on the next cycle.
- rgen_trg set-wins: if rgen_trg coincides with start_go, the latch is set again and applies to the following generation.

FSM (row pass, 13 cycles per row):
- S_IDLE -> S_PRE_READ on start_go.
- S_PRE_READ (rd line 0, rd_adr+1) -> S_READ.
- S_READ (rd_adr+1, saturating at ROWS+1) -> S_SHIFT -> S_CHK, held 8 cycles via a 3-bit chk_idx 0..7.
- S_CHK -> S_JDG -> S_DLT -> S_WRITE.
- S_WRITE: if wr_adr == ROWS+1, go to S_IDLE and assert gen_done; otherwise wr_adr+1 and go to S_READ.
- Generation length = 1 + 13*(ROWS+2) cycles (807 for ROWS = 60).
- The state encoding exposes chk_idx as state = S_CHK_BASE + chk_idx, matching the existing 5-bit phase bus.

Decomposition:
- lfgm_pkg: state_t enum (S_IDLE, S_PRE_READ, S_READ, S_SHIFT, S_CHK_BASE..+7, S_JDG, S_DLT, S_WRITE), CHK_CYC = 8, ROW_CYC = 13.
- Sub-module lfgm_trg_div: synchroniser, falling-edge detect and divider, producing the tick.

Test Plan:
1. trg_div=6, run_en=1, 6 falling edges of start_trg -> one start_go; ram_face 0->1; gnrt_cnt=1; busy for 807 cycles; gen_done after the write to adr 61.
2. Write-pass check over one generation -> wr_en asserted 62 times at adr 0..61; wcf=0 at adr 0 and 61, wcf=1 at adr 1..60; reads cover adr 0..61, each read at least one row ahead of its write.
3. run_en=0: ticks arrive -> no generation starts; a step_req pulse -> exactly one generation; a step_req while busy -> ignored.
4. Run a generation with rgen_trg pulsed mid-generation -> rgen_en=1 for the next generation and 0 for the one after; rgen_trg on the start_go cycle -> rgen_en=1 in the generation after next.
5. trg_div=1 with edges faster than 807 cycles -> overrun=1 and stays 1; only one generation in flight at a time.
6. rst asserted on a cycle in S_CHK of row 30 -> next cycle state=S_IDLE, no wr_en, all outputs at reset values; ROWS=8, ADR_W=4 build -> 131-cycle generation with adr wrapping correctly at 9.

Source files
------------

// File: rtl/lfgm_pkg.sv
// lfgm_pkg: shared phase encoding and row-pass timing for the life-game sequencer.
package lfgm_pkg;
    // The check phases are contiguous, so the phase bus carries S_CHK_BASE + chk_idx.
    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,
        S_PRE_READ = 5'd1,
        S_READ     = 5'd2,
        S_SHIFT    = 5'd3,
        S_CHK_BASE = 5'd4,
        S_CHK_1    = 5'd5,
        S_CHK_2    = 5'd6,
        S_CHK_3    = 5'd7,
        S_CHK_4    = 5'd8,
        S_CHK_5    = 5'd9,
        S_CHK_6    = 5'd10,
        S_CHK_7    = 5'd11,
        S_JDG      = 5'd12,
        S_DLT      = 5'd13,
        S_WRITE    = 5'd14
    } state_t;
    localparam int CHK_CYC = 8;
    localparam int ROW_CYC = 13;
endpackage

// File: rtl/lfgm_trg_div.sv
// lfgm_trg_div: synchronises start_trg, detects falling edges and divides them
// down to a one-cycle tick every max(trg_div,1) edges.
module lfgm_trg_div #(
    parameter int DIV_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_trg,
    input  logic [DIV_W-1:0] trg_div,
    output logic             tick
);
    logic             r_s0, r_s1, r_tick;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_top;
    logic             w_fall;
    assign w_top  = (trg_div == '0) ? '0 : trg_div - DIV_W'(1);
    assign w_fall = r_s1 & ~r_s0;
    assign tick   = r_tick;
    // A count already beyond a newly lowered top wraps on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_s0   <= start_trg;
            r_s1   <= r_s0;
            r_tick <= w_fall & (r_cnt >= w_top);
            if (w_fall)
                r_cnt <= (r_cnt >= w_top) ? '0 : r_cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/lfgm_seq_ctrl.sv
// lfgm_seq_ctrl: generation sequencer driving the row pass (read, shift,
// 8-cycle neighbour check, judge, delta, write) over a walled cell RAM.
module lfgm_seq_ctrl import lfgm_pkg::*; #(
    parameter int ROWS  = 60,
    parameter int ADR_W = 6,
    parameter int GEN_W = 24,
    parameter int DIV_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_trg,
    input  logic [DIV_W-1:0] trg_div,
    input  logic             run_en,
    input  logic             step_req,
    input  logic             rgen_trg,
    output state_t           state,
    output logic [GEN_W-1:0] gnrt_cnt,
    output logic             rgen_en,
    output logic [ADR_W-1:0] adr,
    output logic             rd_en,
    output logic             wr_en,
    output logic             wcf,
    output logic             ram_face,
    output logic             busy,
    output logic             gen_done,
    output logic             overrun
);
    localparam logic [ADR_W-1:0] PARK = ADR_W'(ROWS + 1);
    localparam logic [ADR_W-1:0] LAST_CELL = ADR_W'(ROWS);
    state_t           r_state, w_state_nx;
    logic [ADR_W-1:0] r_rd_adr, r_wr_adr;
    logic [GEN_W-1:0] r_gnrt_cnt;
    logic             r_rgen_en, r_rgen_lat, r_face, r_overrun;
    logic             w_tick, w_start_go, w_last;

    lfgm_trg_div #(.DIV_W(DIV_W)) u_trg_div (
        .clk       (clk),
        .rst       (rst),
        .start_trg (start_trg),
        .trg_div   (trg_div),
        .tick      (w_tick)
    );

    // Apart from IDLE and WRITE, every phase simply advances to the next encoding.
    always_comb begin
        w_start_go = ((w_tick & run_en) | (step_req & ~run_en)) & (r_state == S_IDLE);
        w_last     = (r_state == S_WRITE) && (r_wr_adr == PARK);
        w_state_nx = (r_state == S_IDLE)  ? (w_start_go ? S_PRE_READ : S_IDLE) :
                     (r_state == S_WRITE) ? (w_last ? S_IDLE : S_READ) :
                     state_t'(r_state + 5'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rd_adr   <= PARK;
            r_wr_adr   <= PARK;
            r_gnrt_cnt <= '0;
            r_rgen_en  <= 1'b0;
            r_rgen_lat <= 1'b0;
            r_face     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_rgen_lat <= rgen_trg | (r_rgen_lat & ~w_start_go);
            r_overrun  <= r_overrun | (w_tick & (r_state != S_IDLE));
            if (w_start_go) begin
                r_rd_adr   <= '0;
                r_wr_adr   <= '0;
                r_face     <= ~r_face;
                r_gnrt_cnt <= r_gnrt_cnt + GEN_W'(1);
                r_rgen_en  <= r_rgen_lat;
            end else begin
                if (r_state == S_PRE_READ || (r_state == S_READ && r_rd_adr != PARK))
                    r_rd_adr <= r_rd_adr + ADR_W'(1);
                if (r_state == S_WRITE && !w_last)
                    r_wr_adr <= r_wr_adr + ADR_W'(1);
            end
        end
    end

    assign state    = r_state;
    assign gnrt_cnt = r_gnrt_cnt;
    assign rgen_en  = r_rgen_en;
    assign adr      = (r_state == S_WRITE) ? r_wr_adr : r_rd_adr;
    assign rd_en    = (r_state == S_PRE_READ) || (r_state == S_READ);
    assign wr_en    = (r_state == S_WRITE);
    assign wcf      = (r_wr_adr != '0) && (r_wr_adr <= LAST_CELL);
    assign ram_face = r_face;
    assign busy     = (r_state != S_IDLE);
    assign gen_done = w_last;
    assign overrun  = r_overrun;
endmodule
